fsm_axi_wr: RTL

FSM_AXI_WR -- requirements
Module: fsm_axi_wr

---
 rtl/fsm_axi_wr_pkg.sv | 17 +
 rtl/fsm_axi_wr.sv | 113 +++++++++++
 2 files changed

// File: rtl/fsm_axi_wr_pkg.sv
// Shared definitions for the AXI write/read slave FSMs.
package fsm_axi_wr_pkg;

    // FSM state encoding, shared with the read-side FSM.
    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_AW_READY = 3'd1,
        ST_IF_FULL  = 3'd2,
        ST_W_ACCEPT = 3'd3,
        ST_B_RESP   = 3'd4
    } axi_fsm_state_e;

    localparam logic [1:0] BRESP_OKAY     = 2'b00;
    localparam logic [1:0] BRESP_SLVERR   = 2'b10;
    localparam logic [1:0] BURST_RESERVED = 2'b11;

endpackage

// File: rtl/fsm_axi_wr.sv
// AXI write slave FSM: accepts one AW, streams W beats into a selectable
// data FIFO, then returns a single B response.
module fsm_axi_wr
    import fsm_axi_wr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  axs_s0_awid,
    input  logic [31:0] axs_s0_awaddr,
    input  logic [7:0]  axs_s0_awlen,
    input  logic [2:0]  axs_s0_awsize,
    input  logic [1:0]  axs_s0_awburst,
    input  logic        axs_s0_awvalid,
    output logic        axs_s0_awready,
    input  logic        axs_s0_wvalid,
    input  logic        axs_s0_wlast,
    output logic        axs_s0_wready,
    output logic [3:0]  axs_s0_bid,
    output logic [1:0]  axs_s0_bresp,
    output logic        axs_s0_bvalid,
    input  logic        axs_s0_bready,
    input  logic        in_fifo_full,
    output logic        in_fifo_push,
    output logic [1:0]  in_fifo_push_sel
);

    localparam logic [2:0] INIT     = ST_INIT;
    localparam logic [2:0] AW_READY = ST_AW_READY;
    localparam logic [2:0] IF_FULL  = ST_IF_FULL;
    localparam logic [2:0] W_ACCEPT = ST_W_ACCEPT;
    localparam logic [2:0] B_RESP   = ST_B_RESP;

    logic [2:0] state, state_nx;
    logic [3:0] awid_q;
    logic [7:0] awlen_q;
    logic [1:0] awburst_q;
    logic [1:0] sel_q;
    logic [7:0] beat_cnt;
    logic [1:0] bresp_q;

    logic aw_hs;
    logic last_beat;
    logic burst_end;

    // Beat size and the non-select address bits do not affect this FSM.
    logic unused_ok;
    assign unused_ok = ^{axs_s0_awsize, axs_s0_awaddr[31:10], axs_s0_awaddr[7:0]};

    assign axs_s0_awready   = (state == AW_READY);
    assign axs_s0_wready    = (state == W_ACCEPT) && !in_fifo_full;
    assign axs_s0_bvalid    = (state == B_RESP);
    assign in_fifo_push     = axs_s0_wvalid && axs_s0_wready;
    assign in_fifo_push_sel = sel_q;
    assign axs_s0_bid       = awid_q;
    assign axs_s0_bresp     = bresp_q;

    assign aw_hs     = axs_s0_awready && axs_s0_awvalid;
    // Burst ends at the counted length or an early wlast, whichever is first.
    assign last_beat = (beat_cnt == awlen_q);
    assign burst_end = in_fifo_push && (last_beat || axs_s0_wlast);

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            INIT:     state_nx = AW_READY;
            AW_READY: if (axs_s0_awvalid) state_nx = IF_FULL;
            IF_FULL:  if (!in_fifo_full)  state_nx = W_ACCEPT;
            W_ACCEPT: if (burst_end)      state_nx = B_RESP;
            B_RESP:   if (axs_s0_bready)  state_nx = AW_READY;
            default:  state_nx = INIT;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_nx;
    end

    // AW field capture; push_sel holds until the next AW acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awid_q    <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
            sel_q     <= '0;
        end else if (aw_hs) begin
            awid_q    <= axs_s0_awid;
            awlen_q   <= axs_s0_awlen;
            awburst_q <= axs_s0_awburst;
            sel_q     <= axs_s0_awaddr[9:8];
        end
    end

    // Beat counter: cleared on AW acceptance, bumped on every push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             beat_cnt <= '0;
        else if (aw_hs)        beat_cnt <= '0;
        else if (in_fifo_push) beat_cnt <= beat_cnt + 8'd1;
    end

    // Response is decided on the final beat and held through B_RESP.
    // OKAY needs wlast exactly on the counted last beat and a legal burst type.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bresp_q <= '0;
        else if (burst_end)
            bresp_q <= (axs_s0_wlast && last_beat && (awburst_q != BURST_RESERVED))
                       ? BRESP_OKAY : BRESP_SLVERR;
    end

endmodule
